// File: rtl/register_bank_v2.sv
// Parametrised 2-read / 1-write register file with optional write-to-read
// bypass, hardwired-zero R0 and optionally registered read outputs.
module register_bank_v2 #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 2,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1,
  parameter bit RD_REG  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] dr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              write,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_accept;
  logic [DATA_W-1:0] rv1;
  logic [DATA_W-1:0] rv2;

  // A write to R0 is discarded when R0 is hardwired to zero.
  assign wr_accept = write && !(ZERO_R0 && (dr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_accept) begin
      regs[dr] <= wrData;
    end
  end

  // Zero-R0 has precedence over bypass, bypass over stored contents.
  always_comb begin
    rv1 = regs[sr1];
    if (BYPASS && write && (sr1 == dr)) rv1 = wrData;
    if (ZERO_R0 && (sr1 == '0))         rv1 = '0;
  end

  always_comb begin
    rv2 = regs[sr2];
    if (BYPASS && write && (sr2 == dr)) rv2 = wrData;
    if (ZERO_R0 && (sr2 == '0))         rv2 = '0;
  end

  generate
    if (RD_REG) begin : g_rd_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          rdData1 <= '0;
          rdData2 <= '0;
        end else if (rdEn) begin
          rdData1 <= rv1;
          rdData2 <= rv2;
        end
      end
    end else begin : g_rd_comb
      logic unused_rden;
      assign unused_rden = rdEn;
      assign rdData1     = rv1;
      assign rdData2     = rv2;
    end
  endgenerate

endmodule

// File: tb/tb_register_bank_v2.sv
// Directed bench: three configurations of register_bank_v2 driven from shared
// inputs, each checked against hand-computed values.
module tb_register_bank_v2;

  logic        clk;
  logic        rst;
  logic [1:0]  sr1, sr2, dr;
  logic        rdEn, write;
  logic [31:0] wrData;

  logic [31:0] dut_rd1, dut_rd2;   // ZERO_R0=0 BYPASS=1 RD_REG=0
  logic [31:0] alt_rd1, alt_rd2;   // ZERO_R0=1 BYPASS=0 RD_REG=0
  logic [31:0] reg_rd1, reg_rd2;   // ZERO_R0=1 BYPASS=1 RD_REG=1

  int n_checks = 0;
  int n_fail   = 0;

  register_bank_v2 #(.DATA_W(32), .ADDR_W(2), .ZERO_R0(1'b0), .BYPASS(1'b1), .RD_REG(1'b0)) u_dut (
    .clk(clk), .rst(rst), .sr1(sr1), .sr2(sr2), .rdEn(rdEn), .dr(dr),
    .wrData(wrData), .write(write), .rdData1(dut_rd1), .rdData2(dut_rd2));

  register_bank_v2 #(.DATA_W(32), .ADDR_W(2), .ZERO_R0(1'b1), .BYPASS(1'b0), .RD_REG(1'b0)) u_alt (
    .clk(clk), .rst(rst), .sr1(sr1), .sr2(sr2), .rdEn(rdEn), .dr(dr),
    .wrData(wrData), .write(write), .rdData1(alt_rd1), .rdData2(alt_rd2));

  register_bank_v2 #(.DATA_W(32), .ADDR_W(2), .ZERO_R0(1'b1), .BYPASS(1'b1), .RD_REG(1'b1)) u_reg (
    .clk(clk), .rst(rst), .sr1(sr1), .sr2(sr2), .rdEn(rdEn), .dr(dr),
    .wrData(wrData), .write(write), .rdData1(reg_rd1), .rdData2(reg_rd2));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; rdEn = 1'b0;
    sr1 = 2'd0; sr2 = 2'd0; dr = 2'd0; wrData = 32'h0;
    tick();
    rst = 1'b0;
    chk("reset_reg_rd1", reg_rd1, 32'h0);
    chk("reset_reg_rd2", reg_rd2, 32'h0);

    // 1: every address reads zero after reset on both ports
    for (int a = 0; a < 4; a++) begin
      sr1 = 2'(a); sr2 = 2'(3 - a); rdEn = 1'b1;
      #1;
      chk("reset_dut_rd1", dut_rd1, 32'h0);
      chk("reset_dut_rd2", dut_rd2, 32'h0);
      chk("reset_alt_rd1", alt_rd1, 32'h0);
      chk("reset_alt_rd2", alt_rd2, 32'h0);
      tick();
      chk("reset_regout_rd1", reg_rd1, 32'h0);
      chk("reset_regout_rd2", reg_rd2, 32'h0);
    end

    // 2: write R1, R3 then read back
    rdEn = 1'b0;
    write = 1'b1; dr = 2'd1; wrData = 32'hDEAD_BEEF; tick();
    dr = 2'd3; wrData = 32'h1234_5678; tick();
    write = 1'b0; sr1 = 2'd1; sr2 = 2'd3; rdEn = 1'b1;
    #1;
    chk("wr_dut_rd1", dut_rd1, 32'hDEAD_BEEF);
    chk("wr_dut_rd2", dut_rd2, 32'h1234_5678);
    chk("wr_alt_rd1", alt_rd1, 32'hDEAD_BEEF);
    chk("wr_alt_rd2", alt_rd2, 32'h1234_5678);
    tick();
    chk("wr_reg_rd1", reg_rd1, 32'hDEAD_BEEF);
    chk("wr_reg_rd2", reg_rd2, 32'h1234_5678);
    sr1 = 2'd0; sr2 = 2'd2;
    #1;
    chk("hold_dut_r0", dut_rd1, 32'h0);
    chk("hold_dut_r2", dut_rd2, 32'h0);
    chk("hold_alt_r2", alt_rd2, 32'h0);
    tick();
    chk("hold_reg_r0", reg_rd1, 32'h0);
    chk("hold_reg_r2", reg_rd2, 32'h0);

    // 3: bypass versus stale read on same-cycle write
    write = 1'b1; dr = 2'd2; wrData = 32'h0000_0011; tick();
    wrData = 32'h0000_0022; sr1 = 2'd2; sr2 = 2'd2;
    #1;
    chk("byp_dut_rd1", dut_rd1, 32'h0000_0022);
    chk("byp_dut_rd2", dut_rd2, 32'h0000_0022);
    chk("stale_alt_rd1", alt_rd1, 32'h0000_0011);
    chk("stale_alt_rd2", alt_rd2, 32'h0000_0011);
    tick();
    chk("byp_reg_rd1", reg_rd1, 32'h0000_0022);
    write = 1'b0;
    #1;
    chk("after_alt_rd1", alt_rd1, 32'h0000_0022);
    chk("after_dut_rd1", dut_rd1, 32'h0000_0022);

    // 4: write to R0; zero-R0 configs read 0 even through bypass
    write = 1'b1; dr = 2'd0; wrData = 32'hFFFF_FFFF; sr1 = 2'd0; sr2 = 2'd1;
    #1;
    chk("r0_dut_byp", dut_rd1, 32'hFFFF_FFFF);
    chk("r0_alt_zero", alt_rd1, 32'h0);
    tick();
    chk("r0_reg_zero", reg_rd1, 32'h0);
    chk("r0_reg_rd2", reg_rd2, 32'hDEAD_BEEF);
    write = 1'b0;
    #1;
    chk("r0_dut_stored", dut_rd1, 32'hFFFF_FFFF);
    chk("r0_alt_stored", alt_rd1, 32'h0);
    tick();
    chk("r0_reg_stored", reg_rd1, 32'h0);

    // 5: registered read with rdEn hold
    rdEn = 1'b0; write = 1'b1; dr = 2'd1; wrData = 32'h0000_00A5; sr1 = 2'd1;
    tick();
    write = 1'b0; rdEn = 1'b1; tick();
    chk("rdreg_a5", reg_rd1, 32'h0000_00A5);
    rdEn = 1'b0; write = 1'b1; wrData = 32'h0000_005A; tick();
    write = 1'b0; tick();
    chk("rdreg_hold", reg_rd1, 32'h0000_00A5);
    chk("rdreg_comb_5a", dut_rd1, 32'h0000_005A);
    rdEn = 1'b1; tick();
    chk("rdreg_5a", reg_rd1, 32'h0000_005A);

    // 6: reset beats a same-cycle write; first write accepted after release
    rst = 1'b1; write = 1'b1; dr = 2'd1; wrData = 32'h0000_0077; tick();
    rst = 1'b0; write = 1'b0; sr1 = 2'd1; sr2 = 2'd3;
    chk("rst_reg_rd1", reg_rd1, 32'h0);
    #1;
    chk("rst_dut_rd1", dut_rd1, 32'h0);
    chk("rst_dut_rd2", dut_rd2, 32'h0);
    chk("rst_alt_rd1", alt_rd1, 32'h0);
    write = 1'b1; dr = 2'd3; wrData = 32'h0000_0099;
    #1;
    chk("post_rst_byp", dut_rd2, 32'h0000_0099);
    chk("post_rst_stale", alt_rd2, 32'h0);
    tick();
    write = 1'b0;
    #1;
    chk("post_rst_stored", alt_rd2, 32'h0000_0099);
    chk("post_rst_r1", dut_rd1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
